axi_sram_slave: RTL and testbench
=================================

Name: axi_sram_slave

Overview:
AXI4 slave front-end for one single-port synchronous SRAM macro, which holds either instruction memory or data memory. It sits on a slave port of the AXI interconnect, opposite the CPU-side master wrapper. It accepts INCR read and write bursts, serialises them onto the SRAM port, and returns R and B responses with the transaction IDs echoed back. One clock, one SRAM access per cycle at most.

Parameters:
ID_W, 8, slave-side AXI ID width (master ID plus interconnect prefix)
ADDR_W, 32, AXI address width
DATA_W, 32, AXI data width and SRAM word width
SRAM_AW, 14, SRAM word-address width (16 KiW macro)

Ports:
ACLK  in  1  clock; everything is sampled on its rising edge
ARESETn  in  1  reset, asynchronous assert, active-low
AW channel: AWID_S in ID_W; AWADDR_S in ADDR_W; AWLEN_S in 4; AWSIZE_S in 3; AWBURST_S in 2; AWVALID_S in 1; AWREADY_S out 1
W channel: WDATA_S in DATA_W; WSTRB_S in DATA_W/8; WLAST_S in 1; WVALID_S in 1; WREADY_S out 1
B channel: BID_S out ID_W; BRESP_S out 2; BVALID_S out 1; BREADY_S in 1
AR channel: ARID_S in ID_W; ARADDR_S in ADDR_W; ARLEN_S in 4; ARSIZE_S in 3; ARBURST_S in 2; ARVALID_S in 1; ARREADY_S out 1
R channel: RID_S out ID_W; RDATA_S out DATA_W; RRESP_S out 2; RLAST_S out 1; RVALID_S out 1; RREADY_S in 1
SRAM_CEB out 1 (chip enable, low-active); SRAM_WEB out 1 (1 = read, 0 = write); SRAM_BWEB out DATA_W (bit write enable, low-active)
SRAM_A out SRAM_AW (word address); SRAM_DI out DATA_W (write data); SRAM_DO in DATA_W (read data, valid the cycle after a read edge, held until the next access)

Behaviour:
- Reset (ARESETn low at any time, including mid-burst): state goes to IDLE immediately. All VALID/READY outputs are 0. SRAM_CEB=1, SRAM_WEB=1, SRAM_BWEB all 1. ID, address and counter registers clear to 0. An in-flight burst is dropped with no response.
- FSM states: IDLE, RD_REQ, RD_DATA, WR_DATA, WR_RESP.
- IDLE:
  - AWREADY_S = grant_w and ARREADY_S = grant_r, both combinational from state, the VALIDs and last_served; at most one is high.
  - Only one valid request: that request is granted.
  - Both valid: grant goes to the direction not served last. last_served resets to WRITE, so the first conflict goes to read.
- Read path:
  - AR handshake latches ARID, word address ARADDR[SRAM_AW+1:2], ARLEN; beat counter set to 0; go to RD_REQ.
  - RD_REQ (one cycle): SRAM_CEB=0, SRAM_WEB=1, SRAM_A=current address; go to RD_DATA.
  - RD_DATA: RVALID_S=1, RDATA_S=SRAM_DO, RID_S=latched ID, RRESP_S=2'b00, RLAST_S=(counter==len). Outputs hold stable while RREADY_S=0; the SRAM is idle meanwhile.
  - On R handshake: if last, go to IDLE and set last_served=READ; otherwise counter+1, address+1, go to RD_REQ.
  - Throughput 2 cycles per beat; first RVALID 2 cycles after AR handshake edge.
- Write path:
  - AW handshake latches AWID, word address, AWLEN; go to WR_DATA.
  - WR_DATA: WREADY_S=1. Each W handshake cycle drives SRAM_CEB=0, SRAM_WEB=0, SRAM_A=address, SRAM_DI=WDATA_S, SRAM_BWEB[8i+7:8i]={8{~WSTRB_S[i]}}. Then counter+1 and address+1.
  - Burst end is defined by the counter (counter==len); WLAST_S is not used to terminate. On the final beat go to WR_RESP.
  - WR_RESP: BVALID_S=1, BID_S=latched ID, BRESP_S=2'b00, held until BREADY_S. Then go to IDLE and set last_served=WRITE.
- Address arithmetic:
  - Word address increments modulo 2^SRAM_AW, so 0x3FFF+1 wraps to 0x0000.
  - AxADDR bits above SRAM_AW+1 and bits [1:0] are ignored.
  - AxBURST and AxSIZE are ignored; every transfer is treated as INCR, full word.
- SRAM_CEB=1 in every state/cycle not listed above, and SRAM_BWEB=all 1 on reads.
- No AR/AW is accepted outside IDLE; there is no outstanding-transaction queue.

Decomposition:
- Package axi_slv_pkg: state enum; RESP_OKAY=2'b00; AXI_LEN/SIZE/BURST widths; last_served enum.
- Optional sub-module axi_slv_arb: 2-way round-robin grant with the last_served register.

Test Plan:
- Single read: preload SRAM[0x10]=0xDEADBEEF; AR addr 0x40, len 0, ID 0x12 -> RVALID 2 cycles after handshake, RDATA=0xDEADBEEF, RID=0x12, RLAST=1, RRESP=0.
- Burst read with stall: AR addr 0x100, len 3; hold RREADY=0 for 3 cycles on beat 1 -> 4 beats of words 0x40..0x43 in order; RDATA stable during stall; RLAST only on beat 3; SRAM_CEB high during the stall.
- Strobed write: AW addr 0x8, len 0, ID 0x21; W 0x11223344 with WSTRB=4'b0101 over 0xFFFFFFFF -> SRAM_BWEB=0xFF00FF00; readback 0xFF22FF44; BID=0x21, BRESP=0.
- Simultaneous AR+AW after reset -> read granted first; next simultaneous pair -> write granted; AWREADY and ARREADY never high together.
- Wrap: write burst AW addr 0xFFFC (word 0x3FFF), len 1 -> beats land at words 0x3FFF then 0x0000.
- Reset mid-burst: deassert ARESETn during beat 2 of a len 7 read -> outputs 0 asynchronously, SRAM_CEB=1; after release a new AR completes normally.

Source files
------------

// File: rtl/axi_slv_pkg.sv
// Shared constants for the AXI SRAM slave.
// FSM state codes, response code, channel field widths, arbiter enum.
package axi_slv_pkg;

  localparam int AXI_LEN_W   = 4;
  localparam int AXI_SIZE_W  = 3;
  localparam int AXI_BURST_W = 2;

  localparam logic [1:0] RESP_OKAY = 2'b00;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE    = 3'd0;
  localparam state_t ST_RD_REQ  = 3'd1;
  localparam state_t ST_RD_DATA = 3'd2;
  localparam state_t ST_WR_DATA = 3'd3;
  localparam state_t ST_WR_RESP = 3'd4;

  typedef enum logic {
    SRV_READ  = 1'b0,
    SRV_WRITE = 1'b1
  } served_e;

endpackage

// File: rtl/axi_slv_arb.sv
// Two-way round-robin grant between AR and AW while the slave is idle.
// Ports: ACLK/ARESETn, idle, ar_req/aw_req, rd_done/wr_done in; grant_r/grant_w out.
module axi_slv_arb
  import axi_slv_pkg::*;
(
  input  logic ACLK,
  input  logic ARESETn,
  input  logic idle,
  input  logic ar_req,
  input  logic aw_req,
  input  logic rd_done,
  input  logic wr_done,
  output logic grant_r,
  output logic grant_w
);

  served_e last_q;

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      last_q <= SRV_WRITE;
    end else if (rd_done) begin
      last_q <= SRV_READ;
    end else if (wr_done) begin
      last_q <= SRV_WRITE;
    end
  end

  // Grants are forced low while reset is held so the
  // READY outputs drop asynchronously with ARESETn.
  always_comb begin
    grant_r = 1'b0;
    grant_w = 1'b0;
    if (idle && ARESETn) begin
      if (ar_req && aw_req) begin
        grant_r = (last_q == SRV_WRITE);
        grant_w = (last_q == SRV_READ);
      end else begin
        grant_r = ar_req;
        grant_w = aw_req;
      end
    end
  end

endmodule

// File: rtl/axi_sram_slave.sv
// AXI4 slave serialising INCR bursts onto one single-port SRAM.
// Ports: AW/W/B/AR/R slave channels (*_S), SRAM_CEB/WEB/BWEB/A/DI out, SRAM_DO in.
module axi_sram_slave
  import axi_slv_pkg::*;
#(
  parameter int ID_W    = 8,
  parameter int ADDR_W  = 32,
  parameter int DATA_W  = 32,
  parameter int SRAM_AW = 14
) (
  input  logic                   ACLK,
  input  logic                   ARESETn,
  input  logic [ID_W-1:0]        AWID_S,
  input  logic [ADDR_W-1:0]      AWADDR_S,
  input  logic [AXI_LEN_W-1:0]   AWLEN_S,
  input  logic [AXI_SIZE_W-1:0]  AWSIZE_S,
  input  logic [AXI_BURST_W-1:0] AWBURST_S,
  input  logic                   AWVALID_S,
  output logic                   AWREADY_S,
  input  logic [DATA_W-1:0]      WDATA_S,
  input  logic [DATA_W/8-1:0]    WSTRB_S,
  input  logic                   WLAST_S,
  input  logic                   WVALID_S,
  output logic                   WREADY_S,
  output logic [ID_W-1:0]        BID_S,
  output logic [1:0]             BRESP_S,
  output logic                   BVALID_S,
  input  logic                   BREADY_S,
  input  logic [ID_W-1:0]        ARID_S,
  input  logic [ADDR_W-1:0]      ARADDR_S,
  input  logic [AXI_LEN_W-1:0]   ARLEN_S,
  input  logic [AXI_SIZE_W-1:0]  ARSIZE_S,
  input  logic [AXI_BURST_W-1:0] ARBURST_S,
  input  logic                   ARVALID_S,
  output logic                   ARREADY_S,
  output logic [ID_W-1:0]        RID_S,
  output logic [DATA_W-1:0]      RDATA_S,
  output logic [1:0]             RRESP_S,
  output logic                   RLAST_S,
  output logic                   RVALID_S,
  input  logic                   RREADY_S,
  output logic                   SRAM_CEB,
  output logic                   SRAM_WEB,
  output logic [DATA_W-1:0]      SRAM_BWEB,
  output logic [SRAM_AW-1:0]     SRAM_A,
  output logic [DATA_W-1:0]      SRAM_DI,
  input  logic [DATA_W-1:0]      SRAM_DO
);

  localparam int STRB_W = DATA_W / 8;

  state_t               state_q;
  logic [ID_W-1:0]      id_q;
  logic [SRAM_AW-1:0]   addr_q;
  logic [AXI_LEN_W-1:0] len_q;
  logic [AXI_LEN_W-1:0] cnt_q;

  logic grant_r;
  logic grant_w;
  logic last_beat;
  logic st_idle;
  logic st_rd_req;
  logic st_rd_data;
  logic st_wr_data;
  logic st_wr_resp;
  logic r_hs;
  logic w_hs;
  logic b_hs;
  logic [DATA_W-1:0] bweb_w;

  // Size, burst type, WLAST and out-of-range address bits
  // carry no meaning for a word-wide INCR-only SRAM port.
  logic unused_in;
  assign unused_in = ^{AWSIZE_S, AWBURST_S,
                       ARSIZE_S, ARBURST_S, WLAST_S,
                       AWADDR_S[ADDR_W-1:SRAM_AW+2],
                       AWADDR_S[1:0],
                       ARADDR_S[ADDR_W-1:SRAM_AW+2],
                       ARADDR_S[1:0]};

  assign st_idle    = (state_q == ST_IDLE);
  assign st_rd_req  = (state_q == ST_RD_REQ);
  assign st_rd_data = (state_q == ST_RD_DATA);
  assign st_wr_data = (state_q == ST_WR_DATA);
  assign st_wr_resp = (state_q == ST_WR_RESP);

  assign last_beat = (cnt_q == len_q);
  assign r_hs      = st_rd_data && RREADY_S;
  assign w_hs      = st_wr_data && WVALID_S;
  assign b_hs      = st_wr_resp && BREADY_S;

  axi_slv_arb u_arb (
    .ACLK    (ACLK),
    .ARESETn (ARESETn),
    .idle    (st_idle),
    .ar_req  (ARVALID_S),
    .aw_req  (AWVALID_S),
    .rd_done (r_hs && last_beat),
    .wr_done (b_hs),
    .grant_r (grant_r),
    .grant_w (grant_w)
  );

  always_ff @(posedge ACLK or negedge ARESETn) begin
    if (!ARESETn) begin
      state_q <= ST_IDLE;
      id_q    <= '0;
      addr_q  <= '0;
      len_q   <= '0;
      cnt_q   <= '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (grant_r) begin
            id_q    <= ARID_S;
            addr_q  <= ARADDR_S[SRAM_AW+1:2];
            len_q   <= ARLEN_S;
            cnt_q   <= '0;
            state_q <= ST_RD_REQ;
          end else if (grant_w) begin
            id_q    <= AWID_S;
            addr_q  <= AWADDR_S[SRAM_AW+1:2];
            len_q   <= AWLEN_S;
            cnt_q   <= '0;
            state_q <= ST_WR_DATA;
          end
        end
        ST_RD_REQ: begin
          state_q <= ST_RD_DATA;
        end
        ST_RD_DATA: begin
          if (RREADY_S) begin
            if (last_beat) begin
              state_q <= ST_IDLE;
            end else begin
              cnt_q   <= cnt_q + 1'b1;
              addr_q  <= addr_q + 1'b1;
              state_q <= ST_RD_REQ;
            end
          end
        end
        ST_WR_DATA: begin
          if (WVALID_S) begin
            cnt_q  <= cnt_q + 1'b1;
            addr_q <= addr_q + 1'b1;
            if (last_beat) begin
              state_q <= ST_WR_RESP;
            end
          end
        end
        ST_WR_RESP: begin
          if (BREADY_S) begin
            state_q <= ST_IDLE;
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    bweb_w = '1;
    for (int i = 0; i < STRB_W; i++) begin
      bweb_w[8*i +: 8] = {8{~WSTRB_S[i]}};
    end
  end

  always_comb begin
    SRAM_CEB  = 1'b1;
    SRAM_WEB  = 1'b1;
    SRAM_BWEB = '1;
    SRAM_A    = addr_q;
    SRAM_DI   = WDATA_S;
    unique case (1'b1)
      st_rd_req: begin
        SRAM_CEB = 1'b0;
      end
      w_hs: begin
        SRAM_CEB  = 1'b0;
        SRAM_WEB  = 1'b0;
        SRAM_BWEB = bweb_w;
      end
      default: begin
      end
    endcase
  end

  assign AWREADY_S = grant_w;
  assign ARREADY_S = grant_r;
  assign WREADY_S  = st_wr_data;

  assign BVALID_S = st_wr_resp;
  assign BID_S    = id_q;
  assign BRESP_S  = RESP_OKAY;

  assign RVALID_S = st_rd_data;
  assign RID_S    = id_q;
  assign RDATA_S  = SRAM_DO;
  assign RRESP_S  = RESP_OKAY;
  assign RLAST_S  = st_rd_data && last_beat;

endmodule

// File: tb/tb_axi_sram_slave.sv
// Randomised bench for axi_sram_slave with an SRAM model and a
// phase-level AXI reference model checked on every falling edge.
module tb_axi_sram_slave;

  logic        ACLK;
  logic        ARESETn;
  logic [7:0]  AWID_S;
  logic [31:0] AWADDR_S;
  logic [3:0]  AWLEN_S;
  logic [2:0]  AWSIZE_S;
  logic [1:0]  AWBURST_S;
  logic        AWVALID_S;
  logic        AWREADY_S;
  logic [31:0] WDATA_S;
  logic [3:0]  WSTRB_S;
  logic        WLAST_S;
  logic        WVALID_S;
  logic        WREADY_S;
  logic [7:0]  BID_S;
  logic [1:0]  BRESP_S;
  logic        BVALID_S;
  logic        BREADY_S;
  logic [7:0]  ARID_S;
  logic [31:0] ARADDR_S;
  logic [3:0]  ARLEN_S;
  logic [2:0]  ARSIZE_S;
  logic [1:0]  ARBURST_S;
  logic        ARVALID_S;
  logic        ARREADY_S;
  logic [7:0]  RID_S;
  logic [31:0] RDATA_S;
  logic [1:0]  RRESP_S;
  logic        RLAST_S;
  logic        RVALID_S;
  logic        RREADY_S;
  logic        SRAM_CEB;
  logic        SRAM_WEB;
  logic [31:0] SRAM_BWEB;
  logic [13:0] SRAM_A;
  logic [31:0] SRAM_DI;
  logic [31:0] SRAM_DO;

  axi_sram_slave dut (
    .ACLK(ACLK), .ARESETn(ARESETn),
    .AWID_S(AWID_S), .AWADDR_S(AWADDR_S), .AWLEN_S(AWLEN_S),
    .AWSIZE_S(AWSIZE_S), .AWBURST_S(AWBURST_S),
    .AWVALID_S(AWVALID_S), .AWREADY_S(AWREADY_S),
    .WDATA_S(WDATA_S), .WSTRB_S(WSTRB_S), .WLAST_S(WLAST_S),
    .WVALID_S(WVALID_S), .WREADY_S(WREADY_S),
    .BID_S(BID_S), .BRESP_S(BRESP_S),
    .BVALID_S(BVALID_S), .BREADY_S(BREADY_S),
    .ARID_S(ARID_S), .ARADDR_S(ARADDR_S), .ARLEN_S(ARLEN_S),
    .ARSIZE_S(ARSIZE_S), .ARBURST_S(ARBURST_S),
    .ARVALID_S(ARVALID_S), .ARREADY_S(ARREADY_S),
    .RID_S(RID_S), .RDATA_S(RDATA_S), .RRESP_S(RRESP_S),
    .RLAST_S(RLAST_S), .RVALID_S(RVALID_S), .RREADY_S(RREADY_S),
    .SRAM_CEB(SRAM_CEB), .SRAM_WEB(SRAM_WEB), .SRAM_BWEB(SRAM_BWEB),
    .SRAM_A(SRAM_A), .SRAM_DI(SRAM_DI), .SRAM_DO(SRAM_DO)
  );

  initial ACLK = 1'b0;
  always #5 ACLK = ~ACLK;

  int total = 0;
  int bad = 0;

  task automatic chk(input string name, input logic [63:0] act,
                     input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h t=%0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] init_val(input int a);
    logic [31:0] v;
    case (a)
      'h10:    v = 32'hDEADBEEF;
      'h02:    v = 32'hFFFFFFFF;
      'h40:    v = 32'hA0000040;
      'h41:    v = 32'hA0000041;
      'h42:    v = 32'hA0000042;
      'h43:    v = 32'hA0000043;
      default: v = (32'(a) * 32'h9E3779B1) ^ 32'h5A5A0000;
    endcase
    return v;
  endfunction

  // SRAM macro model
  logic [31:0] sram [int];

  function automatic logic [31:0] sram_peek(input int a);
    return sram.exists(a) ? sram[a] : init_val(a);
  endfunction

  always @(posedge ACLK) begin
    if (!SRAM_CEB) begin
      if (!SRAM_WEB) begin
        sram[int'(SRAM_A)] = (sram_peek(int'(SRAM_A)) & SRAM_BWEB)
                           | (SRAM_DI & ~SRAM_BWEB);
      end else begin
        SRAM_DO <= sram_peek(int'(SRAM_A));
      end
    end
  end

  // Reference model: expected memory image plus transaction phase
  logic [31:0] refm [int];

  function automatic logic [31:0] ref_peek(input int a);
    return refm.exists(a) ? refm[a] : init_val(a);
  endfunction

  bit        m_rq, m_rd, m_wd, m_wr;
  bit        m_last_wr;
  bit        m_idle, m_er, m_ew;
  int        m_rbase, m_rlen, m_rbeat;
  int        m_wbase, m_wlen, m_wbeat;
  int        m_a;
  logic [7:0]  m_rid, m_wid;
  logic [31:0] m_bweb, m_new;
  logic [31:0] last_bweb;

  always @(negedge ACLK) begin
    if (!ARESETn) begin
      m_rq = 0; m_rd = 0; m_wd = 0; m_wr = 0;
      m_last_wr = 1;
    end else begin
      m_idle = !(m_rq || m_rd || m_wd || m_wr);
      if (m_idle) begin
        m_er = ARVALID_S && (!AWVALID_S || m_last_wr);
        m_ew = AWVALID_S && !m_er;
        chk("arready", ARREADY_S, m_er);
        chk("awready", AWREADY_S, m_ew);
        chk("idle_ceb", SRAM_CEB, 1);
        chk("idle_valids", {RVALID_S, WREADY_S, BVALID_S}, 0);
        if (m_er) begin
          m_rq = 1; m_rbeat = 0;
          m_rbase = int'(ARADDR_S[15:2]);
          m_rlen = int'(ARLEN_S); m_rid = ARID_S;
        end else if (m_ew) begin
          m_wd = 1; m_wbeat = 0;
          m_wbase = int'(AWADDR_S[15:2]);
          m_wlen = int'(AWLEN_S); m_wid = AWID_S;
        end
      end else begin
        chk("busy_ready", {ARREADY_S, AWREADY_S}, 0);
        if (m_rq) begin
          m_a = (m_rbase + m_rbeat) % 16384;
          chk("rreq_rvalid", RVALID_S, 0);
          chk("rreq_ceb_web", {SRAM_CEB, SRAM_WEB}, 2'b01);
          chk("rreq_bweb", SRAM_BWEB, 32'hFFFFFFFF);
          chk("rreq_addr", SRAM_A, m_a);
          m_rq = 0; m_rd = 1;
        end else if (m_rd) begin
          m_a = (m_rbase + m_rbeat) % 16384;
          chk("rvalid", RVALID_S, 1);
          chk("rid", RID_S, m_rid);
          chk("rdata", RDATA_S, ref_peek(m_a));
          chk("rlast", RLAST_S, m_rbeat == m_rlen);
          chk("rresp", RRESP_S, 0);
          chk("rdata_ceb", SRAM_CEB, 1);
          if (RREADY_S) begin
            if (m_rbeat == m_rlen) begin
              m_rd = 0; m_last_wr = 0;
            end else begin
              m_rbeat++; m_rq = 1;
            end
          end
        end else if (m_wd) begin
          chk("wready", WREADY_S, 1);
          chk("w_rvalid", RVALID_S, 0);
          if (WVALID_S) begin
            m_a = (m_wbase + m_wbeat) % 16384;
            m_new = ref_peek(m_a);
            for (int i = 0; i < 4; i++) begin
              m_bweb[8*i +: 8] = WSTRB_S[i] ? 8'h00 : 8'hFF;
              if (WSTRB_S[i]) m_new[8*i +: 8] = WDATA_S[8*i +: 8];
            end
            chk("w_ceb_web", {SRAM_CEB, SRAM_WEB}, 2'b00);
            chk("w_addr", SRAM_A, m_a);
            chk("w_di", SRAM_DI, WDATA_S);
            chk("w_bweb", SRAM_BWEB, m_bweb);
            last_bweb = SRAM_BWEB;
            refm[m_a] = m_new;
            m_wbeat++;
            if (m_wbeat > m_wlen) begin
              m_wd = 0; m_wr = 1;
            end
          end else begin
            chk("wgap_ceb", SRAM_CEB, 1);
          end
        end else if (m_wr) begin
          chk("bvalid", BVALID_S, 1);
          chk("bid", BID_S, m_wid);
          chk("bresp", BRESP_S, 0);
          chk("b_wready", WREADY_S, 0);
          chk("b_ceb", SRAM_CEB, 1);
          if (BREADY_S) begin
            m_wr = 0; m_last_wr = 1;
          end
        end
      end
    end
  end

  // Drivers
  logic [31:0] got_r[$];
  logic [7:0]  got_bid;
  logic [31:0] wdat [16];
  logic [3:0]  wstb [16];

  task automatic chk_rst(input string tag);
    chk({tag, "_readys"}, {AWREADY_S, ARREADY_S, WREADY_S}, 0);
    chk({tag, "_valids"}, {BVALID_S, RVALID_S}, 0);
    chk({tag, "_ceb_web"}, {SRAM_CEB, SRAM_WEB}, 2'b11);
    chk({tag, "_bweb"}, SRAM_BWEB, 32'hFFFFFFFF);
  endtask

  task automatic do_read(input logic [7:0] id, input logic [31:0] addr,
                         input int len, input int stall_beat,
                         input int stall_n, input int abort_beat);
    int beat, cyc, stalled;
    bit rv;
    ARID_S = id; ARADDR_S = addr; ARLEN_S = 4'(len);
    ARSIZE_S = 3'($urandom); ARBURST_S = 2'($urandom);
    ARVALID_S = 1;
    cyc = 0;
    @(negedge ACLK);
    while (!ARREADY_S && cyc < 100) begin
      @(negedge ACLK); cyc++;
    end
    chk("ar_handshake", ARREADY_S, 1);
    if (!ARREADY_S) begin
      ARVALID_S = 0;
      return;
    end
    @(posedge ACLK); #1;
    ARVALID_S = 0;
    beat = 0; cyc = 0; stalled = 0;
    while (beat <= len && cyc < 200) begin
      RREADY_S = 0;
      if (RVALID_S) begin
        if (beat == abort_beat) begin
          ARESETn = 0;
          #1;
          chk_rst("abort");
          repeat (2) @(posedge ACLK);
          #1;
          ARESETn = 1;
          return;
        end
        if (beat == stall_beat && stalled < stall_n) begin
          stalled++;
        end else begin
          RREADY_S = 1;
          got_r.push_back(RDATA_S);
        end
      end
      rv = RVALID_S && RREADY_S;
      @(posedge ACLK); #1;
      cyc++;
      if (rv) beat++;
    end
    RREADY_S = 0;
    chk("r_beats", beat, len + 1);
  endtask

  task automatic do_write(input logic [7:0] id, input logic [31:0] addr,
                          input int len, input bit gaps);
    int b, cyc;
    bit hs;
    AWID_S = id; AWADDR_S = addr; AWLEN_S = 4'(len);
    AWSIZE_S = 3'($urandom); AWBURST_S = 2'($urandom);
    AWVALID_S = 1;
    cyc = 0;
    @(negedge ACLK);
    while (!AWREADY_S && cyc < 100) begin
      @(negedge ACLK); cyc++;
    end
    chk("aw_handshake", AWREADY_S, 1);
    if (!AWREADY_S) begin
      AWVALID_S = 0;
      return;
    end
    @(posedge ACLK); #1;
    AWVALID_S = 0;
    b = 0; cyc = 0;
    while (b <= len && cyc < 200) begin
      if (gaps && $urandom_range(0, 3) == 0) begin
        WVALID_S = 0;
      end else begin
        WVALID_S = 1;
        WDATA_S = wdat[b];
        WSTRB_S = wstb[b];
        WLAST_S = gaps ? 1'($urandom) : (b == len);
      end
      hs = WVALID_S && WREADY_S;
      @(posedge ACLK); #1;
      cyc++;
      if (hs) b++;
    end
    WVALID_S = 0; WLAST_S = 0;
    chk("w_beats", b, len + 1);
    cyc = 0; hs = 0;
    while (!hs && cyc < 100) begin
      BREADY_S = BVALID_S && (!gaps || $urandom_range(0, 1) == 1);
      hs = BREADY_S;
      if (hs) got_bid = BID_S;
      @(posedge ACLK); #1;
      cyc++;
    end
    BREADY_S = 0;
    chk("b_handshake", hs, 1);
  endtask

  task automatic pulse_reset();
    ARESETn = 0;
    #1;
    chk_rst("rst_pulse");
    repeat (2) @(posedge ACLK);
    #1;
    ARESETn = 1;
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog expired t=%0t", $time);
    $fatal(1, "watchdog");
  end

  initial begin
    int kind, len, sb, sn;
    ARESETn = 0;
    AWID_S = 0; AWADDR_S = 0; AWLEN_S = 0; AWSIZE_S = 0; AWBURST_S = 0;
    WDATA_S = 0; WSTRB_S = 0; WLAST_S = 0; WVALID_S = 0; BREADY_S = 0;
    ARID_S = 0; ARADDR_S = 0; ARLEN_S = 0; ARSIZE_S = 0; ARBURST_S = 0;
    RREADY_S = 0;
    AWVALID_S = 1; ARVALID_S = 1;
    #2;
    chk_rst("rst0");
    repeat (3) @(posedge ACLK);
    #1;
    AWVALID_S = 0; ARVALID_S = 0;
    ARESETn = 1;
    @(posedge ACLK); #1;

    // single read
    got_r.delete();
    do_read(8'h12, 32'h40, 0, -1, 0, -1);
    chk("t1_size", got_r.size(), 1);
    chk("t1_data", got_r[0], 32'hDEADBEEF);

    // burst read with stall on beat 1
    got_r.delete();
    do_read(8'h34, 32'h100, 3, 1, 3, -1);
    chk("t2_size", got_r.size(), 4);
    chk("t2_b0", got_r[0], 32'hA0000040);
    chk("t2_b1", got_r[1], 32'hA0000041);
    chk("t2_b2", got_r[2], 32'hA0000042);
    chk("t2_b3", got_r[3], 32'hA0000043);

    // strobed write then readback
    wdat[0] = 32'h11223344; wstb[0] = 4'b0101;
    do_write(8'h21, 32'h8, 0, 0);
    chk("t3_bweb", last_bweb, 32'hFF00FF00);
    chk("t3_bid", got_bid, 8'h21);
    got_r.delete();
    do_read(8'h01, 32'h8, 0, -1, 0, -1);
    chk("t3_rdback", got_r[0], 32'hFF22FF44);

    // arbitration after reset
    pulse_reset();
    @(posedge ACLK); #1;
    ARID_S = 8'h31; ARADDR_S = 32'h200; ARLEN_S = 0; ARVALID_S = 1;
    AWID_S = 8'h32; AWADDR_S = 32'h300; AWLEN_S = 0; AWVALID_S = 1;
    #1;
    chk("pair1_ar", ARREADY_S, 1);
    chk("pair1_aw", AWREADY_S, 0);
    wdat[0] = 32'hCAFE0001; wstb[0] = 4'hF;
    do_read(8'h31, 32'h200, 0, -1, 0, -1);
    do_write(8'h32, 32'h300, 0, 0);
    do_read(8'h33, 32'h204, 1, -1, 0, -1);
    ARID_S = 8'h41; ARADDR_S = 32'h208; ARLEN_S = 0; ARVALID_S = 1;
    AWID_S = 8'h42; AWADDR_S = 32'h30C; AWLEN_S = 0; AWVALID_S = 1;
    #1;
    chk("pair2_ar", ARREADY_S, 0);
    chk("pair2_aw", AWREADY_S, 1);
    wdat[0] = 32'hCAFE0002; wstb[0] = 4'hF;
    do_write(8'h42, 32'h30C, 0, 0);
    do_read(8'h41, 32'h208, 0, -1, 0, -1);

    // address wrap
    wdat[0] = 32'h11112222; wstb[0] = 4'hF;
    wdat[1] = 32'h33334444; wstb[1] = 4'hF;
    do_write(8'h05, 32'h0000FFFC, 1, 0);
    chk("t5_top", sram_peek(16383), 32'h11112222);
    chk("t5_wrap", sram_peek(0), 32'h33334444);

    // reset during beat 2 of an 8-beat read
    do_read(8'h07, 32'h600, 7, -1, 0, 2);
    got_r.delete();
    do_read(8'h08, 32'hFFFF0101, 0, -1, 0, -1);
    chk("t6_after", got_r[0], 32'hA0000040);

    // random traffic
    for (int n = 0; n < 40; n++) begin
      kind = $urandom_range(0, 1);
      len = $urandom_range(0, 15);
      if (kind == 0) begin
        sb = $urandom_range(0, len);
        sn = $urandom_range(0, 3);
        do_read(8'($urandom), $urandom, len, sb, sn, -1);
      end else begin
        for (int i = 0; i < 16; i++) begin
          wdat[i] = $urandom;
          wstb[i] = 4'($urandom);
        end
        do_write(8'($urandom), $urandom, len, 1);
      end
    end

    repeat (3) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
